// File: rtl/jumper_sense.sv
// Jumper-to-ground sense stage: synchronise, debounce and latch a config word.
// Optional live monitoring of the latched word while locked: `define JUMPER_SENSE_LIVE_EN.
module jumper_sense #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] J,
    input  logic             RESAMPLE,
    output logic [WIDTH-1:0] CONFIG,
    output logic             VALID,
    output logic             CHANGED
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0]   ALL_OPEN = {WIDTH{1'b1}};

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    logic [WIDTH-1:0] j_raw_s;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] config_q, config_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;

    logic             stable_s;
    logic             cnt_done_s;
    logic [WIDTH-1:0] new_cfg_s;

    // Only a hard 0 counts as a fitted jumper; z/x behave like the pull-up.
    always_comb begin
        j_raw_s = ALL_OPEN;
        for (int i = 0; i < WIDTH; i++) begin
            j_raw_s[i] = (J[i] === 1'b0) ? 1'b0 : 1'b1;
        end
    end

    // Two-flop synchroniser plus one-cycle-old copy for the stability compare.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            s1_q   <= ALL_OPEN;
            s2_q   <= ALL_OPEN;
            prev_q <= ALL_OPEN;
        end else begin
            s1_q   <= j_raw_s;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign stable_s   = (s2_q == prev_q);
    assign cnt_done_s = (cnt_q == CNT_MAX);
    assign new_cfg_s  = ~s2_q;

    // Debounce/lock next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        config_d  = config_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (RESAMPLE || !stable_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_done_s) begin
                    state_d   = ST_LOCKED;
                    cnt_d     = CNT_ZERO;
                    config_d  = new_cfg_s;
                    valid_d   = 1'b1;
                    changed_d = valid_q && (new_cfg_s != config_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOCKED: begin
                if (RESAMPLE) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ZERO;
`ifdef JUMPER_SENSE_LIVE_EN
                // Count only while a stable value differs from the latched word.
                end else if (!stable_s || (new_cfg_s == config_q)) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_done_s) begin
                    cnt_d     = CNT_ZERO;
                    config_d  = new_cfg_s;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`else
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= CNT_ZERO;
            config_q  <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            config_q  <= config_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign CONFIG  = config_q;
    assign VALID   = valid_q;
    assign CHANGED = changed_q;

endmodule

// File: tb/tb_jumper_sense.sv
// Scoreboard bench for jumper_sense: expected output events are queued with
// their cycle number and matched against every observed change of the outputs.
module tb_jumper_sense;

    localparam int W = 4;
    localparam int N = 16;

    typedef struct {
        int         cyc;
        logic [3:0] cfg;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       resample = 1'b0;
    logic [3:0] j_oe = 4'hF;
    logic [3:0] j_val = 4'hF;
    wire  [3:0] j_w;
    logic [3:0] cfg_o;
    logic       valid_o;
    logic       changed_o;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    logic       mon_valid_p = 1'b0;
    logic [3:0] mon_cfg_p = 4'h0;

    // Open-drain style pins with board pull-ups; undriven bits read high.
    for (genvar g = 0; g < W; g++) begin : g_pin
        wire pin;
        pullup pu (pin);
        assign pin = j_oe[g] ? j_val[g] : 1'bz;
        assign j_w[g] = pin;
    end

    jumper_sense #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .CLK(clk), .nRESET(rst_n), .J(j_w), .RESAMPLE(resample),
        .CONFIG(cfg_o), .VALID(valid_o), .CHANGED(changed_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t cyc=%0d)", tag, obs, expv, $time, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] cfg, input logic chg);
        exp_t e;
        e.cyc = c;
        e.cfg = cfg;
        e.chg = chg;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic [3:0] oe, input logic [3:0] val);
        @(negedge clk);
        rst_n = 1'b0;
        resample = 1'b0;
        j_oe = oe;
        j_val = val;
        exp_q.delete();
        #1;
        chk("rst_config", int'(cfg_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_changed", int'(changed_o), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, "_config"}, int'(cfg_o), 0);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_changed"}, int'(changed_o), 0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Any change of VALID/CONFIG, or CHANGED high, is an output event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_valid_p = 1'b0;
            mon_cfg_p = 4'h0;
        end else begin
            if ((valid_o != mon_valid_p) || (cfg_o != mon_cfg_p) || changed_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_event", int'({valid_o, cfg_o, changed_o}),
                        int'({mon_valid_p, mon_cfg_p, 1'b0}));
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_cycle", cyc, e.cyc);
                    chk("evt_config", int'(cfg_o), int'(e.cfg));
                    chk("evt_valid", int'(valid_o), 1);
                    chk("evt_changed", int'(changed_o), int'(e.chg));
                end
            end
            mon_valid_p = valid_o;
            mon_cfg_p = cfg_o;
        end
    end

    initial begin
        int e0;

        // All open from reset: lock at edge N.
        do_reset(4'hF, 4'hF);
        push_exp(N, 4'h0, 1'b0);
        wait_drain(3 * N);
        repeat (10) @(negedge clk);

        // Two jumpers fitted: synchroniser adds three edges.
        do_reset(4'hF, 4'b1010);
        push_exp(N + 3, 4'b0101, 1'b0);
        wait_drain(3 * N);

        // zz1z: undriven pins read open.
        do_reset(4'b0010, 4'b0010);
        push_exp(N, 4'h0, 1'b0);
        wait_drain(3 * N);

        // Bit0 bounces every 5 cycles for 40 cycles, ending fitted.
        do_reset(4'hF, 4'b1110);
        for (int k = 0; k < 8; k++) begin
            repeat (5) @(negedge clk);
            j_val[0] = ~j_val[0];
        end
        push_exp(cyc + N + 3, 4'b0001, 1'b0);
        wait_drain(3 * N);

        // Resample onto a new jumper set: CONFIG holds, then changes with CHANGED.
        @(negedge clk);
        j_val = 4'b0111;
        resample = 1'b1;
        e0 = cyc;
        @(negedge clk);
        resample = 1'b0;
        push_exp(e0 + N + 3, 4'b1000, 1'b1);
        wait_drain(3 * N);

        // Resample with J unchanged: re-lock must not pulse CHANGED.
        @(negedge clk);
        resample = 1'b1;
        @(negedge clk);
        resample = 1'b0;
        repeat (2 * N) @(negedge clk);
        chk("relock_same_config", int'(cfg_o), int'(4'b1000));
        chk("relock_same_valid", int'(valid_o), 1);

        // RESAMPLE held: lock N edges after it falls.
        @(negedge clk);
        j_val = 4'b1010;
        resample = 1'b1;
        repeat (30) @(negedge clk);
        resample = 1'b0;
        e0 = cyc;
        push_exp(e0 + N, 4'b0101, 1'b1);
        wait_drain(3 * N);

        // Asynchronous reset while locked; debounce restarts from zero.
        async_reset("rst_locked");
        push_exp(N + 3, 4'b0101, 1'b0);
        wait_drain(3 * N);

        // Asynchronous reset mid re-debounce while CONFIG/VALID still held.
        @(negedge clk);
        j_val = 4'b0000;
        resample = 1'b1;
        @(negedge clk);
        resample = 1'b0;
        repeat (8) @(negedge clk);
        chk("settle_hold_config", int'(cfg_o), int'(4'b0101));
        async_reset("rst_settle");
        push_exp(N + 3, 4'b1111, 1'b0);
        wait_drain(3 * N);

        // Jumper change while locked with no RESAMPLE.
        do_reset(4'hF, 4'hF);
        push_exp(N, 4'h0, 1'b0);
        wait_drain(3 * N);
        @(negedge clk);
        j_val = 4'b1101;
        e0 = cyc;
`ifdef JUMPER_SENSE_LIVE_EN
        push_exp(e0 + N + 3, 4'b0010, 1'b1);
        wait_drain(3 * N);
`else
        repeat (3 * N) @(negedge clk);
        chk("frozen_config", int'(cfg_o), 0);
`endif
        chk("live_valid", int'(valid_o), 1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/jumper_sense.md
Name: jumper_sense

Overview:
- Consumer stage for the board's jumper-to-ground lines. Each line is pulled high externally and pulled low when its jumper is fitted.
- Synchronises and debounces each line, then latches a stable configuration word for the chipset config logic.
- Flags when the word is valid and when a later resample changes it.
- Sits between the jumper pin models and the configuration registers.

Parameters:
WIDTH, 4, number of jumper lines sensed
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before locking (legal range 2..65535)

Ports:
CLK  input  1  system clock; all state on rising edge
nRESET  input  1  asynchronous active-low reset
J  input  WIDTH  raw jumper lines; 0 = jumper fitted, 1/z/x = open
RESAMPLE  input  1  request re-debounce and re-latch of J
CONFIG  output  WIDTH  latched configuration; bit=1 means jumper fitted (inverse of J)
VALID  output  1  CONFIG holds a debounced value
CHANGED  output  1  one-cycle pulse when a re-lock produces a CONFIG different from the previous one

Behaviour:
- Clock and reset: one clock, CLK. Reset nRESET is asynchronous and active-low. Assertion immediately forces all state to reset values, including mid-debounce or while LOCKED.
- Reset values: CONFIG = 0, VALID = 0, CHANGED = 0, state = SETTLE, counter = 0. Sync stages s1/s2 and compare register prev are all ones (open).
- Input conditioning: each J bit is sampled as 0 only when it is exactly 0; z/x read as 1, which models the pull-up. Two-flop synchroniser J -> s1 -> s2. Every edge, prev <= s2.
- Stability: stable = (s2 == prev), using pre-edge values.
- Counter: width clog2(DEBOUNCE_CYCLES). It saturates only by leaving SETTLE; it never wraps.
- States: SETTLE and LOCKED.
- SETTLE, per edge, in this priority:
  - RESAMPLE=1 or !stable: counter <= 0.
  - Otherwise, counter == DEBOUNCE_CYCLES-1: lock. CONFIG <= ~s2, VALID <= 1, state <= LOCKED, counter <= 0. CHANGED <= 1 iff VALID was already 1 and ~s2 != CONFIG.
  - Otherwise: counter <= counter+1.
- LOCKED:
  - J activity is ignored.
  - RESAMPLE=1: state <= SETTLE, counter <= 0.
  - VALID and CONFIG keep their old value throughout re-debounce. There is no glitch on CONFIG.
- RESAMPLE held high keeps the block in SETTLE indefinitely. Lock occurs on the first qualifying edge after it falls.
- CHANGED is high for exactly one cycle, coincident with the new CONFIG. It is never asserted on the first lock after reset.
- Latency, J constant since reset:
  - All open: VALID rises at edge DEBOUNCE_CYCLES.
  - Any bit fitted: VALID rises at edge DEBOUNCE_CYCLES+3.
  - Edges are counted from the first rising edge after nRESET deasserts.
- Bounce: any s2 change restarts the full DEBOUNCE_CYCLES window. Continuous bounce faster than the window means VALID never asserts. That is the required behaviour.

Optional Feature:
- Macro: JUMPER_SENSE_LIVE_EN.
- Defined: LOCKED keeps running the debounce counter on s2. When the new stable value ~s2 differs from CONFIG for DEBOUNCE_CYCLES cycles, CONFIG updates and CHANGED pulses, with no RESAMPLE needed and VALID staying 1. RESAMPLE behaves as without the macro.
- Undefined: CONFIG is frozen in LOCKED until RESAMPLE or reset. No live-monitor counter logic is present.

Test Plan:
- Reset release, J=4'b1111 constant, DEBOUNCE_CYCLES=16 -> VALID rises at edge 16, CONFIG=4'b0000, CHANGED never 1.
- Reset release, J=4'b1010 constant -> VALID rises at edge 19, CONFIG=4'b0101. J=4'bzz1z -> CONFIG=4'b0000 (z reads open).
- J=4'b1110, bit0 toggles every 5 cycles for 40 cycles, then held 0 -> VALID stays 0 during bounce, then rises 16 cycles after the last s2 change, CONFIG=4'b0001.
- Locked at CONFIG=4'b0001; set J=4'b0111, pulse RESAMPLE 1 cycle -> CONFIG stays 4'b0001 and VALID stays 1 during settle, then CONFIG=4'b1000 with CHANGED high exactly 1 cycle. Repeat with J unchanged -> re-lock with CHANGED=0.
- Assert nRESET low mid-SETTLE and mid-LOCKED, asynchronously between edges -> CONFIG=0, VALID=0 and CHANGED=0 immediately. Debounce restarts from zero after release.
- Macro defined: locked at 4'b0000, drive J=4'b1101 with no RESAMPLE -> CONFIG=4'b0010 and one CHANGED pulse after 16+3 edges. Macro undefined: same stimulus -> CONFIG stays 4'b0000.
